// File: rtl/obuf_a_arb_pkg.sv
// Shared mesh constants for the A-channel output stage: port indices, payload layout and defaults.
package obuf_a_arb_pkg;

  localparam int unsigned N_PORT = 5;

  localparam int unsigned P_L = 0;
  localparam int unsigned P_N = 1;
  localparam int unsigned P_E = 2;
  localparam int unsigned P_S = 3;
  localparam int unsigned P_W = 4;

  localparam int unsigned MESH_PYLD_W = 17;
  localparam int unsigned OBUF_DEPTH  = 2;

  // Payload layout {qos, type, src_pos, data}, LSB first.
  localparam int unsigned DATA_LSB    = 0;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned SRC_POS_LSB = 8;
  localparam int unsigned SRC_POS_W   = 6;
  localparam int unsigned TYPE_LSB    = 14;
  localparam int unsigned TYPE_W      = 2;
  localparam int unsigned QOS_LSB     = 16;
  localparam int unsigned QOS_W       = 1;

  typedef struct packed {
    logic [QOS_W-1:0]     qos;
    logic [TYPE_W-1:0]    typ;
    logic [SRC_POS_W-1:0] src_pos;
    logic [DATA_W-1:0]    data;
  } a_pyld_t;

  // Index visited at rotation offset off after the last winner, wrapping mod n.
  function automatic int unsigned rr_idx(int unsigned last, int unsigned off, int unsigned n);
    return (last + off) % n;
  endfunction

endpackage

// File: rtl/obuf_a_arb_if.sv
// Handshake bundle between the input buffers / outgoing link and the output-port arbiter stage.
interface obuf_a_arb_if #(
  parameter int unsigned PYLD_W = obuf_a_arb_pkg::MESH_PYLD_W,
  parameter int unsigned N_IN   = obuf_a_arb_pkg::N_PORT,
  parameter int unsigned DEPTH  = obuf_a_arb_pkg::OBUF_DEPTH
) ();

  logic [N_IN-1:0]          req_i;
  logic [N_IN*PYLD_W-1:0]   pyld_i;
  logic [N_IN-1:0]          gnt_o;
  logic                     obuf_rdy_o;
  logic                     link_vld_o;
  logic                     link_rdy_i;
  logic [PYLD_W-1:0]        link_pyld_o;
  logic [$clog2(DEPTH):0]   occ_o;

  modport slave (
    input  req_i, pyld_i, link_rdy_i,
    output gnt_o, obuf_rdy_o, link_vld_o, link_pyld_o, occ_o
  );

  modport master (
    output req_i, pyld_i, link_rdy_i,
    input  gnt_o, obuf_rdy_o, link_vld_o, link_pyld_o, occ_o
  );

endinterface

// File: rtl/obuf_a_arb_rr_arb.sv
// Round-robin arbiter: the requester after the last winner has highest priority; the pointer
// only moves when a grant is actually issued.
module obuf_a_arb_rr_arb
  import obuf_a_arb_pkg::*;
#(
  parameter int unsigned N = N_PORT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  logic [IdxW-1:0] last_q, last_d;
  logic [IdxW-1:0] win;
  logic            found;

  always_comb begin
    found = 1'b0;
    win   = last_q;
    for (int unsigned off = 1; off <= N; off++) begin
      if (!found && req_i[rr_idx(32'(last_q), off, N)]) begin
        found = 1'b1;
        win   = IdxW'(rr_idx(32'(last_q), off, N));
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (found && en_i) gnt_o[win] = 1'b1;
    last_d = (found && en_i) ? win : last_q;
  end

  // Reset to N-1 so input 0 is first in line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= IdxW'(N - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/obuf_a_arb.sv
// Output-port stage: round-robin grant over the input buffers, small FIFO, vld/rdy outgoing link.
// Readiness and grant depend only on registered occupancy, never on link_rdy_i.
module obuf_a_arb
  import obuf_a_arb_pkg::*;
#(
  parameter int unsigned PYLD_W = MESH_PYLD_W,
  parameter int unsigned N_IN   = N_PORT,
  parameter int unsigned DEPTH  = OBUF_DEPTH
) (
  input logic         clk,
  input logic         rst,
  obuf_a_arb_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]   occ_q, occ_d;
  logic [PYLD_W-1:0] mem_q [DEPTH];
  logic [PYLD_W-1:0] mem_d [DEPTH];

  logic              full, obuf_rdy, link_vld, push, pop;
  logic [N_IN-1:0]   gnt;
  logic [PYLD_W-1:0] sel_pyld;

  always_comb begin
    full     = (occ_q == OccW'(DEPTH));
    obuf_rdy = ~full;
    link_vld = (occ_q != '0);
    push     = |gnt;
    pop      = link_vld & bus.link_rdy_i;
  end

  obuf_a_arb_rr_arb #(
    .N(N_IN)
  ) u_rr_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (bus.req_i),
    .en_i  (obuf_rdy),
    .gnt_o (gnt)
  );

  // One-hot AND-OR select of the granted payload.
  always_comb begin
    sel_pyld = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      sel_pyld = sel_pyld | (bus.pyld_i[k*PYLD_W +: PYLD_W] & {PYLD_W{gnt[k]}});
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = sel_pyld;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      mem_q    <= mem_d;
    end
  end

  assign bus.gnt_o       = gnt;
  assign bus.obuf_rdy_o  = obuf_rdy;
  assign bus.link_vld_o  = link_vld;
  assign bus.link_pyld_o = mem_q[rd_ptr_q];
  assign bus.occ_o       = occ_q;

endmodule

// File: tb/tb_obuf_a_arb.sv
// Bench for obuf_a_arb: directed vector table, hand-written corner sequences and a random run
// checked against a queue-based model of the arbiter and FIFO.
module tb_obuf_a_arb;

  localparam int unsigned PW = 17;
  localparam int unsigned N  = 5;
  localparam int unsigned D  = 2;
  localparam int unsigned OW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  obuf_a_arb_if #(.PYLD_W(PW), .N_IN(N), .DEPTH(D)) bus ();

  obuf_a_arb #(.PYLD_W(PW), .N_IN(N), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [N*PW-1:0] pv;
  logic [PW-1:0]   mq[$];
  int              m_last;
  int              g_win;
  int              wait_cnt[N];
  int              max_wait;

  logic [N-1:0]  act_gnt;
  logic [OW-1:0] act_occ;
  logic          act_rdy, act_vld;
  logic [PW-1:0] act_pyld;

  typedef struct {
    logic [N-1:0]  req;
    logic          lrdy;
    logic [N-1:0]  gnt;
    logic [OW-1:0] occ;
    logic          rdy;
    logic          vld;
    int            pidx;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pk(input int k);
    return PW'(32'h0A5A0 + k * 32'h111);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last = N - 1;
    for (int k = 0; k < N; k++) wait_cnt[k] = 0;
  endtask

  // Drive one cycle from just after negedge, sample at +1, update the model at posedge.
  task automatic step(input logic [N-1:0] req, input logic lrdy);
    logic [N-1:0]  exp_gnt;
    logic [PW-1:0] tmp;
    bus.req_i      = req;
    bus.link_rdy_i = lrdy;
    bus.pyld_i     = pv;
    #1;
    act_gnt  = bus.gnt_o;
    act_occ  = bus.occ_o;
    act_rdy  = bus.obuf_rdy_o;
    act_vld  = bus.link_vld_o;
    act_pyld = bus.link_pyld_o;
    g_win    = -1;
    if (mq.size() < D && req != '0) begin
      for (int off = 1; off <= N; off++) begin
        if (g_win < 0 && req[(m_last + off) % N]) g_win = (m_last + off) % N;
      end
    end
    exp_gnt = '0;
    if (g_win >= 0) exp_gnt[g_win] = 1'b1;
    chk("gnt", 32'(act_gnt), 32'(exp_gnt));
    chk("gnt_onehot0", 32'($onehot0(act_gnt)), 32'd1);
    chk("occ", 32'(act_occ), mq.size());
    chk("obuf_rdy", 32'(act_rdy), 32'(mq.size() < D));
    chk("link_vld", 32'(act_vld), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("link_pyld", 32'(act_pyld), 32'(mq[0]));
    for (int k = 0; k < N; k++) begin
      if (!req[k] || g_win == k) wait_cnt[k] = 0;
      else if (g_win >= 0) wait_cnt[k]++;
      if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
    end
    @(posedge clk);
    if (lrdy && mq.size() != 0) tmp = mq.pop_front();
    if (g_win >= 0) begin
      mq.push_back(pv[g_win*PW +: PW]);
      m_last = g_win;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] rq;
    logic         lr;
    bit           held;

    max_wait = 0;
    for (int k = 0; k < N; k++) pv[k*PW +: PW] = pk(k);
    bus.req_i      = '0;
    bus.pyld_i     = pv;
    bus.link_rdy_i = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_occ", 32'(bus.occ_o), 32'd0);
    chk("rst_rdy", 32'(bus.obuf_rdy_o), 32'd1);
    chk("rst_vld", 32'(bus.link_vld_o), 32'd0);
    chk("rst_pyld", 32'(bus.link_pyld_o), 32'd0);
    chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: rotation with a free link, then fill/stall/free with a blocked link.
    tbl[0]  = '{5'b11111, 1'b1, 5'b00001, 2'd0, 1'b1, 1'b0, -1};
    tbl[1]  = '{5'b11111, 1'b1, 5'b00010, 2'd1, 1'b1, 1'b1, 0};
    tbl[2]  = '{5'b11111, 1'b1, 5'b00100, 2'd1, 1'b1, 1'b1, 1};
    tbl[3]  = '{5'b11111, 1'b1, 5'b01000, 2'd1, 1'b1, 1'b1, 2};
    tbl[4]  = '{5'b11111, 1'b1, 5'b10000, 2'd1, 1'b1, 1'b1, 3};
    tbl[5]  = '{5'b00000, 1'b1, 5'b00000, 2'd1, 1'b1, 1'b1, 4};
    tbl[6]  = '{5'b00000, 1'b1, 5'b00000, 2'd0, 1'b1, 1'b0, -1};
    tbl[7]  = '{5'b00100, 1'b0, 5'b00100, 2'd0, 1'b1, 1'b0, -1};
    tbl[8]  = '{5'b00100, 1'b0, 5'b00100, 2'd1, 1'b1, 1'b1, 2};
    tbl[9]  = '{5'b00100, 1'b0, 5'b00000, 2'd2, 1'b0, 1'b1, 2};
    tbl[10] = '{5'b00100, 1'b1, 5'b00000, 2'd2, 1'b0, 1'b1, 2};
    tbl[11] = '{5'b00100, 1'b0, 5'b00100, 2'd1, 1'b1, 1'b1, 2};
    tbl[12] = '{5'b00000, 1'b0, 5'b00000, 2'd2, 1'b0, 1'b1, 2};
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].req, tbl[i].lrdy);
      chk($sformatf("tbl%0d_gnt", i), 32'(act_gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_occ", i), 32'(act_occ), 32'(tbl[i].occ));
      chk($sformatf("tbl%0d_rdy", i), 32'(act_rdy), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_vld", i), 32'(act_vld), 32'(tbl[i].vld));
      if (tbl[i].pidx >= 0) chk($sformatf("tbl%0d_pyld", i), 32'(act_pyld), 32'(pk(tbl[i].pidx)));
    end
    step('0, 1'b1);
    step('0, 1'b1);

    // Simultaneous push and pop at occupancy 1
    step(5'b00001, 1'b0);
    step(5'b00010, 1'b1);
    chk("pp_occ_before", 32'(act_occ), 32'd1);
    chk("pp_head_before", 32'(act_pyld), 32'(pk(0)));
    step('0, 1'b0);
    chk("pp_occ_after", 32'(act_occ), 32'd1);
    chk("pp_head_after", 32'(act_pyld), 32'(pk(1)));
    step('0, 1'b1);

    // Rotation from last=2 over a sparse request set
    step(5'b00100, 1'b1);
    chk("rot_set_last", 32'(act_gnt), 32'b00100);
    step(5'b01011, 1'b1);
    chk("rot_first", 32'(act_gnt), 32'b01000);
    step(5'b01011, 1'b1);
    chk("rot_second", 32'(act_gnt), 32'b00001);
    step(5'b01011, 1'b1);
    chk("rot_third", 32'(act_gnt), 32'b00010);
    step('0, 1'b1);

    // Reset asserted mid-cycle while full
    step(5'b00001, 1'b0);
    step(5'b00001, 1'b0);
    bus.req_i = '0;
    #1;
    chk("pre_rst_occ", 32'(bus.occ_o), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(bus.link_vld_o), 32'd0);
    chk("mid_rst_occ", 32'(bus.occ_o), 32'd0);
    chk("mid_rst_rdy", 32'(bus.obuf_rdy_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(5'b10000, 1'b1);
    chk("post_rst_gnt", 32'(act_gnt), 32'b10000);

    // Random traffic; a held request keeps its payload until granted.
    rq = 5'b10000;
    for (int i = 0; i < 10000; i++) begin
      logic [N-1:0] nrq;
      for (int k = 0; k < N; k++) begin
        held = rq[k] && (g_win != k);
        nrq[k] = held ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
        if (!held) pv[k*PW +: PW] = PW'($urandom);
      end
      rq = nrq;
      if ((i % 1000) < 500) lr = ($urandom_range(0, 3) != 0);
      else                  lr = ($urandom_range(0, 3) == 0);
      step(rq, lr);
    end
    chk("max_wait_bounded", 32'(max_wait <= N - 1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
